gray_updown_counter: RTL and testbench
======================================

# gray_updown_counter

Parametrised Gray-code subsystem succeeding the fixed 4-bit Gray-to-binary converter. It contains two independent channels:
- a loadable up/down counter that publishes its state in both Gray and binary form, with a wrap flag;
- a registered Gray-to-binary decode channel with a valid qualifier.

It sits between multi-bit counters and consumers that need glitch-free single-bit-change encodings, e.g. pointer exchange across blocks.

## Interface
- WIDTH, 4, bit width of counter, load value, Gray and binary buses; legal range 2..32.
- clk  input  1  rising-edge clock; single clock for the whole block.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- en  input  1  counter step enable.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load strobe; has priority over en.
- d_bin  input  WIDTH  binary load value.
- g  output  WIDTH  registered Gray form of counter state.
- b  output  WIDTH  registered binary form of counter state.
- wrap  output  1  one-cycle pulse on counter wrap-around.
- g_in  input  WIDTH  external Gray word to decode.
- g_in_vld  input  1  g_in qualifier.
- b_out  output  WIDTH  registered binary decode of last valid g_in.
- b_out_vld  output  1  registered copy of g_in_vld.
- err  output  1  sticky Gray-sequence violation flag; see Configuration.

## Operation
- Reset (rst_n=0 at a clk edge) clears all outputs:
  - g, b, b_out = 0.
  - wrap, b_out_vld, err = 0.
  - Clears checker history.
  - Overrides load, en and g_in_vld in the same cycle.
- Counter state update priority: reset > load > en > hold.
  - load=1: b <= d_bin; g <= d_bin ^ (d_bin >> 1); wrap <= 0. en and up are ignored.
  - en=1, up=1: b <= (b + 1) mod 2^WIDTH.
  - en=1, up=0: b <= (b - 1) mod 2^WIDTH.
  - en=0, load=0: b and g hold; wrap <= 0.
- g is always the Gray encoding of b, registered in the same cycle. g and b never disagree.
- Consecutive counter g values differ in exactly one bit on every en step, including wrap. load may change any number of bits.
- wrap is registered and is 1 only for the cycle after a step that:
  - goes up from all-ones to 0, or
  - goes down from 0 to all-ones.
  - load never asserts wrap, even if the loaded value crosses the boundary.
- Decode channel, independent of the counter:
  - When g_in_vld=1: b_out <= binary of g_in, where b_out[WIDTH-1] = g_in[WIDTH-1] and b_out[i] = b_out[i+1] ^ g_in[i].
  - When g_in_vld=0: b_out holds its value.
  - b_out_vld <= g_in_vld every cycle.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Counter: 1-cycle latency from load/en to g and b; wrap is coincident with the wrapping g/b value.
- Decoder: 1-cycle latency. b_out and b_out_vld update on the edge after g_in_vld is sampled high. Back-to-back valid samples give full throughput.
- Reset asserted mid-count or mid-stream takes effect at the next edge. The cycle after reset behaves as after power-up reset.
- load and en both high in one cycle: load wins, no step occurs.

## Configuration
- GRAY_UPDOWN_CHECK_EN defined:
  - The block keeps the last valid g_in.
  - On each later valid sample, if popcount(g_in ^ last) > 1, err is set to 1 with the same timing as b_out_vld for that sample.
  - err stays 1 until reset.
  - The first valid sample after reset is not checked.
  - Zero bits changed is legal.
- GRAY_UPDOWN_CHECK_EN undefined: the checker logic is absent and err is tied to 0.

## Test plan
- WIDTH=4, reset, then en=1 up=1 for 16 cycles:
  - g = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
  - wrap=1 only on the cycle g returns to 0000.
- From reset, en=1 up=0 for one cycle -> b=1111, g=1000, wrap=1; next cycle with en=0 -> wrap=0.
- load=1, en=1, up=1, d_bin=1010 -> next cycle b=1010, g=1111, wrap=0. Then load=1 with d_bin=0000 from b=1111 -> wrap stays 0.
- g_in=1101 with g_in_vld=1, then g_in_vld=0 for 3 cycles:
  - b_out=1001 and b_out_vld=1 after one cycle;
  - b_out holds 1001 with b_out_vld=0 afterwards.
- Checker, with GRAY_UPDOWN_CHECK_EN defined: valid g_in 0000, 0001, 0011 -> err=0. Next valid 0000 (two bits change) -> err=1 and stays 1. Same stimulus with the macro undefined -> err=0 throughout.
- Count to b=0101, then rst_n=0 for one edge with load=1 and g_in_vld=1 -> all outputs 0 next cycle; counting resumes from 0 after rst_n=1.

Source files
------------

// File: rtl/gray_updown_counter.sv
// Loadable up/down counter publishing Gray and binary state with a wrap pulse,
// plus an independent registered Gray-to-binary decode channel.
// Optional Gray-sequence checker on the decode input: define GRAY_UPDOWN_CHECK_EN.
module gray_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d_bin,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b,
  output logic             wrap,
  input  logic [WIDTH-1:0] g_in,
  input  logic             g_in_vld,
  output logic [WIDTH-1:0] b_out,
  output logic             b_out_vld,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] g_reg, g_next;
  logic             wrap_reg, wrap_next;
  logic [WIDTH-1:0] b_out_reg, b_out_next;
  logic             b_out_vld_reg;
  logic [WIDTH-1:0] dec_bin;

  // Counter next state: load beats en; wrap only on a boundary-crossing step.
  always_comb begin
    b_next    = b_reg;
    wrap_next = 1'b0;
    if (load) begin
      b_next = d_bin;
    end else if (en) begin
      if (up) begin
        b_next    = b_reg + ONE;
        wrap_next = (b_reg == ALL_ONES);
      end else begin
        b_next    = b_reg - ONE;
        wrap_next = (b_reg == '0);
      end
    end
    g_next = b_next ^ (b_next >> 1);
  end

  // Each binary bit is the XOR of all Gray bits at or above its position.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign dec_bin[gi] = ^(g_in >> gi);
    end
  endgenerate

  assign b_out_next = g_in_vld ? dec_bin : b_out_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_reg         <= '0;
      g_reg         <= '0;
      wrap_reg      <= 1'b0;
      b_out_reg     <= '0;
      b_out_vld_reg <= 1'b0;
    end else begin
      b_reg         <= b_next;
      g_reg         <= g_next;
      wrap_reg      <= wrap_next;
      b_out_reg     <= b_out_next;
      b_out_vld_reg <= g_in_vld;
    end
  end

  assign b         = b_reg;
  assign g         = g_reg;
  assign wrap      = wrap_reg;
  assign b_out     = b_out_reg;
  assign b_out_vld = b_out_vld_reg;

`ifdef GRAY_UPDOWN_CHECK_EN
  logic [WIDTH-1:0] last_reg;
  logic             have_last_reg;
  logic             err_reg;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;

  // Clearing the lowest set bit leaves something only if two or more bits changed.
  assign diff      = g_in ^ last_reg;
  assign multi_bit = |(diff & (diff - ONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_reg      <= '0;
      have_last_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else if (g_in_vld) begin
      last_reg      <= g_in;
      have_last_reg <= 1'b1;
      if (have_last_reg && multi_bit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Self-checking bench for gray_updown_counter (WIDTH=4): vector table,
// hand-written corner sequences, and randomized traffic against a behavioural model.
module tb_gray_updown_counter;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;
`ifdef GRAY_UPDOWN_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, en, up, load, g_in_vld;
  logic [W-1:0] d_bin, g_in;
  logic [W-1:0] g, b, b_out;
  logic         wrap, b_out_vld, err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .d_bin(d_bin),
    .g(g), .b(b), .wrap(wrap), .g_in(g_in), .g_in_vld(g_in_vld),
    .b_out(b_out), .b_out_vld(b_out_vld), .err(err)
  );

  typedef struct {
    logic         rst_n, en, up, load;
    logic [W-1:0] d_bin, g_in;
    logic         g_in_vld;
    logic [W-1:0] e_g, e_b;
    logic         e_wrap;
    logic [W-1:0] e_bout;
    logic         e_bvld;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(logic r, logic e, logic u, logic l, logic [W-1:0] d,
                              logic [W-1:0] gi, logic gv, logic [W-1:0] eg,
                              logic [W-1:0] eb, logic ew, logic [W-1:0] ebo, logic ebv);
    vec_t v;
    v.rst_n = r; v.en = e; v.up = u; v.load = l; v.d_bin = d; v.g_in = gi;
    v.g_in_vld = gv; v.e_g = eg; v.e_b = eb; v.e_wrap = ew; v.e_bout = ebo; v.e_bvld = ebv;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic e, logic u, logic l, logic [W-1:0] d,
                       logic [W-1:0] gi, logic gv);
    rst_n = r; en = e; up = u; load = l; d_bin = d; g_in = gi; g_in_vld = gv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: plain integer arithmetic, Gray by definition,
  // decode by searching for the value whose Gray code matches.
  int   m_b, m_bout, m_last;
  logic m_wrap, m_bvld, m_err, m_have;

  function automatic int to_gray(int v);
    return v ^ (v >> 1);
  endfunction

  function automatic int from_gray(int gv);
    for (int v = 0; v <= MAX; v++) if (to_gray(v) == gv) return v;
    return -1;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_b = 0; m_wrap = 0; m_bout = 0; m_bvld = 0; m_err = 0; m_have = 0; m_last = 0;
    end else begin
      if (load) begin
        m_b = int'(d_bin); m_wrap = 0;
      end else if (en && up) begin
        m_wrap = (m_b == MAX); m_b = (m_b + 1) % (MAX + 1);
      end else if (en) begin
        m_wrap = (m_b == 0); m_b = (m_b + MAX) % (MAX + 1);
      end else begin
        m_wrap = 0;
      end
      m_bvld = g_in_vld;
      if (g_in_vld) begin
        m_bout = from_gray(int'(g_in));
        if (CHK && m_have && $countones(int'(g_in) ^ m_last) > 1) m_err = 1;
        m_last = int'(g_in);
        m_have = 1;
      end
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".g"}, 32'(g), 32'(to_gray(m_b)));
    chk({tag, ".b"}, 32'(b), 32'(m_b));
    chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    chk({tag, ".b_out"}, 32'(b_out), 32'(m_bout));
    chk({tag, ".b_out_vld"}, 32'(b_out_vld), 32'(m_bvld));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
  endtask

  initial begin
    logic [W-1:0] gseq [16];
    logic [W-1:0] prev_g;
    string tag;

    gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
             4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    //                  rst en up ld d_bin  g_in   vld  e_g    e_b    wrap e_bout vld
    vecs[0] = mk(0, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h0, 0);
    for (int i = 1; i <= 16; i++)
      vecs[i] = mk(1, 1, 1, 0, 4'h0, 4'h0, 0, gseq[i-1], W'(i % 16), (i == 16), 4'h0, 0);
    vecs[17] = mk(1, 0, 1, 0, 4'h0, 4'h0, 0, 4'b0000, 4'b0000, 0, 4'h0, 0);
    vecs[18] = mk(1, 1, 0, 0, 4'h0, 4'h0, 0, 4'b1000, 4'b1111, 1, 4'h0, 0);
    vecs[19] = mk(1, 0, 0, 0, 4'h0, 4'h0, 0, 4'b1000, 4'b1111, 0, 4'h0, 0);
    vecs[20] = mk(1, 1, 1, 1, 4'b1010, 4'h0, 0, 4'b1111, 4'b1010, 0, 4'h0, 0);
    vecs[21] = mk(1, 0, 1, 1, 4'b1111, 4'h0, 0, 4'b1000, 4'b1111, 0, 4'h0, 0);
    vecs[22] = mk(1, 1, 1, 1, 4'b0000, 4'h0, 0, 4'b0000, 4'b0000, 0, 4'h0, 0);
    vecs[23] = mk(1, 0, 0, 0, 4'h0, 4'b1101, 1, 4'b0000, 4'b0000, 0, 4'b1001, 1);
    for (int i = 24; i <= 26; i++)
      vecs[i] = mk(1, 0, 0, 0, 4'h0, 4'b0110, 0, 4'b0000, 4'b0000, 0, 4'b1001, 0);

    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].d_bin,
            vecs[i].g_in, vecs[i].g_in_vld);
      tick();
      tag = $sformatf("vec%0d", i);
      $display("%s: g=%b b=%b wrap=%b b_out=%b b_out_vld=%b err=%b",
               tag, g, b, wrap, b_out, b_out_vld, err);
      chk({tag, ".g"}, 32'(g), 32'(vecs[i].e_g));
      chk({tag, ".b"}, 32'(b), 32'(vecs[i].e_b));
      chk({tag, ".wrap"}, 32'(wrap), 32'(vecs[i].e_wrap));
      chk({tag, ".b_out"}, 32'(b_out), 32'(vecs[i].e_bout));
      chk({tag, ".b_out_vld"}, 32'(b_out_vld), 32'(vecs[i].e_bvld));
      chk({tag, ".err"}, 32'(err), 32'(1'b0));
    end

    // Checker sequence: single-bit steps are clean, a two-bit jump latches err.
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 4'b0000, 1); tick();
    drive(1, 0, 0, 0, 0, 4'b0001, 1); tick();
    drive(1, 0, 0, 0, 0, 4'b0011, 1); tick();
    $display("chk_clean: err=%b", err);
    chk("chk_clean.err", 32'(err), 32'(1'b0));
    drive(1, 0, 0, 0, 0, 4'b0000, 1); tick();
    $display("chk_jump: err=%b b_out=%b", err, b_out);
    chk("chk_jump.err", 32'(err), 32'(CHK));
    chk("chk_jump.b_out", 32'(b_out), 32'(4'b0000));
    drive(1, 0, 0, 0, 0, 4'b0001, 1); tick();
    drive(1, 0, 0, 0, 0, 4'b0001, 0); tick();
    $display("chk_sticky: err=%b", err);
    chk("chk_sticky.err", 32'(err), 32'(CHK));
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("chk_reset.err", 32'(err), 32'(1'b0));
    // First valid after reset is a large jump from the old history but must not flag.
    drive(1, 0, 0, 0, 0, 4'b1111, 1); tick();
    chk("chk_first.err", 32'(err), 32'(1'b0));

    // Reset mid-count overrides load and g_in_vld, then counting restarts from zero.
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 0, 0, 0, 0); tick();
    end
    chk("midrst.pre_b", 32'(b), 32'(4'b0101));
    drive(0, 1, 1, 1, 4'b1010, 4'b1111, 1); tick();
    $display("midrst: g=%b b=%b wrap=%b b_out=%b b_out_vld=%b err=%b",
             g, b, wrap, b_out, b_out_vld, err);
    chk("midrst.g", 32'(g), 32'(0));
    chk("midrst.b", 32'(b), 32'(0));
    chk("midrst.b_out", 32'(b_out), 32'(0));
    chk("midrst.b_out_vld", 32'(b_out_vld), 32'(0));
    drive(1, 1, 1, 0, 0, 0, 0); tick();
    chk("midrst.resume_b", 32'(b), 32'(1));
    chk("midrst.resume_g", 32'(g), 32'(1));

    // Randomized traffic against the model.
    drive(0, 0, 0, 0, 0, 0, 0);
    model_step(); tick(); chk_model("rnd_init");
    prev_g = '0;
    for (int i = 0; i < 300; i++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      load     = ($urandom_range(0, 7) == 0);
      en       = $urandom_range(0, 3) != 0;
      up       = $urandom_range(0, 1) == 1;
      d_bin    = W'($urandom);
      g_in_vld = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) != 0) g_in = prev_g ^ W'(1 << $urandom_range(0, W - 1));
      else g_in = W'($urandom);
      if (g_in_vld) prev_g = g_in;
      model_step();
      tick();
      tag = $sformatf("rnd%0d", i);
      $display("%s: rst_n=%b ld=%b en=%b up=%b d=%b g_in=%b vld=%b -> g=%b b=%b wrap=%b b_out=%b vld=%b err=%b",
               tag, rst_n, load, en, up, d_bin, g_in, g_in_vld,
               g, b, wrap, b_out, b_out_vld, err);
      chk_model(tag);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
